// File: rtl/ieee_adder_issue.sv
// rtl/ieee_adder_issue.sv - operand issue FIFO ahead of the IEEE-754 single adder
// Classifies specials at enqueue; head entry falls through to the adder or result mux.
module ieee_adder_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_a,
    output logic [31:0]              out_b,
    output logic                     out_sub,
    output logic                     out_bypass,
    output logic [31:0]              out_bypass_result,
    output logic [CNT_W-1:0]         flush_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        bypass;
        logic [31:0] res;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          entry_d;
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W:0]  cnt_sum;
    logic            full, empty, push, pop;
    logic            a_nan, b_nan, a_inf, b_inf, a_den, b_den, eff_sb;
    logic [1:0]      n_den;

    always_comb begin
        a_nan  = (&in_a[30:23]) && (|in_a[22:0]);
        b_nan  = (&in_b[30:23]) && (|in_b[22:0]);
        a_inf  = (&in_a[30:23]) && !(|in_a[22:0]);
        b_inf  = (&in_b[30:23]) && !(|in_b[22:0]);
        a_den  = (in_a[30:23] == 8'd0) && (|in_a[22:0]);
        b_den  = (in_b[30:23] == 8'd0) && (|in_b[22:0]);
        eff_sb = in_b[31] ^ in_sub;
        n_den  = {1'b0, a_den} + {1'b0, b_den};

        entry_d.a      = a_den ? {in_a[31], 31'd0} : in_a;
        entry_d.b      = b_den ? {in_b[31], 31'd0} : in_b;
        entry_d.sub    = in_sub;
        entry_d.bypass = 1'b1;
        // Priority order matters: opposing infinities must yield NaN before either Inf wins.
        if (a_nan || b_nan)
            entry_d.res = QNAN;
        else if (a_inf && b_inf && (in_a[31] != eff_sb))
            entry_d.res = QNAN;
        else if (a_inf)
            entry_d.res = {in_a[31], 8'hFF, 23'd0};
        else if (b_inf)
            entry_d.res = {eff_sb, 8'hFF, 23'd0};
        else begin
            entry_d.res    = 32'd0;
            entry_d.bypass = 1'b0;
        end
    end

    always_comb begin
        full     = (level_q == FULL_LVL);
        empty    = (level_q == '0);
        in_ready = !full;
        push     = in_valid && !full;
        pop      = out_ready && !empty;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + (AW+1)'(1);
        else if (pop && !push)
            level_d = level_q - (AW+1)'(1);

        cnt_sum = {1'b0, flush_q} + (CNT_W+1)'(n_den);
        flush_d = flush_q;
        if (push)
            flush_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            flush_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            flush_q  <= flush_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= entry_d;
    end

    always_comb begin
        head              = empty ? '0 : mem_q[rd_ptr_q];
        out_valid         = !empty;
        out_a             = head.a;
        out_b             = head.b;
        out_sub           = head.sub;
        out_bypass        = head.bypass;
        out_bypass_result = head.res;
        flush_count       = flush_q;
        level             = level_q;
    end
endmodule

// File: tb/tb_ieee_adder_issue.sv
// tb/tb_ieee_adder_issue.sv - scoreboard bench for ieee_adder_issue
module tb_ieee_adder_issue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready, out_sub, out_bypass;
    logic [31:0] out_a, out_b, out_bypass_result;
    logic [CNT_W-1:0] flush_count;
    logic [$clog2(DEPTH):0] level;

    ieee_adder_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sub(out_sub),
        .out_bypass(out_bypass), .out_bypass_result(out_bypass_result),
        .flush_count(flush_count), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        bypass;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_flush = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic sb_eff;
        logic ainf, binf, anan, bnan;
        anan   = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bnan   = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ainf   = (a[30:0] == 31'h7F80_0000);
        binf   = (b[30:0] == 31'h7F80_0000);
        sb_eff = b[31] ^ s;
        e.sub  = s;
        e.a    = (a[30:23] == 0 && a[22:0] != 0) ? (a & 32'h8000_0000) : a;
        e.b    = (b[30:23] == 0 && b[22:0] != 0) ? (b & 32'h8000_0000) : b;
        e.bypass = anan || bnan || ainf || binf;
        if (anan || bnan || (ainf && binf && a[31] != sb_eff)) e.res = 32'h7FC0_0000;
        else if (ainf) e.res = a;
        else if (binf) e.res = {sb_eff, 31'h7F80_0000};
        else           e.res = 32'd0;
        return e;
    endfunction

    function automatic int n_denorm(input logic [31:0] a, input logic [31:0] b);
        return int'(a[30:23] == 0 && a[22:0] != 0) + int'(b[30:23] == 0 && b[22:0] != 0);
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            2: begin x[30:23] = 8'hFF; x[22:0] = '0; end
            default: ;
        endcase
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_state();
        exp_t h;
        h = (sb.size() > 0) ? sb[0] : '0;
        chk("level",      32'(level),          32'(sb.size()));
        chk("in_ready",   32'(in_ready),       32'(sb.size() < DEPTH));
        chk("out_valid",  32'(out_valid),      32'(sb.size() > 0));
        chk("flush",      32'(flush_count),    32'(exp_flush));
        chk("out_a",      out_a,               h.a);
        chk("out_b",      out_b,               h.b);
        chk("out_sub",    32'(out_sub),        32'(h.sub));
        chk("out_bypass", 32'(out_bypass),     32'(h.bypass));
        chk("bypass_res", out_bypass_result,   h.res);
    endtask

    // One clock cycle: check settled outputs, drive inputs, then update the model after the edge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r);
        logic do_push, do_pop;
        @(negedge clk);
        check_state();
        in_valid = v; in_a = a; in_b = b; in_sub = s; out_ready = r;
        do_push = v && (sb.size() < DEPTH);
        do_pop  = r && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) begin
            sb.push_back(model(a, b, s));
            exp_flush = exp_flush + n_denorm(a, b);
            if (exp_flush > 255) exp_flush = 255;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_out_a",     out_a,          32'd0);
        chk("rst_flush",     32'(flush_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // first push appears on the next edge
        cyc(1, 32'h3F80_0000, 32'h4000_0000, 0, 0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_a",     out_a,          32'h3F80_0000);
        chk("first_byp",   32'(out_bypass), 32'd0);
        chk("first_level", 32'(level),     32'd1);
        cyc(0, 0, 0, 0, 1);

        // fill to DEPTH, refuse a 5th push (even with a concurrent pop), then drain in order
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 32'h4100_0000 + i, 32'h3F00_0000 + i, i[0], 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0);
        cyc(1, 32'hCAFE_F00D, 32'h1111_1111, 1, 1);
        chk("pop_from_full_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 0, 0, 0, 1);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // steady push+pop at level 2 across pointer wrap
        cyc(1, 32'h4040_0000, 32'h4080_0000, 0, 0);
        cyc(1, 32'h40A0_0000, 32'h40C0_0000, 1, 0);
        for (int i = 0; i < 10; i++)
            cyc(1, 32'h4200_0000 + 32'(i), 32'hC200_0000 + 32'(i), i[0], 1);
        chk("steady_level", 32'(level), 32'd2);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // infinities
        cyc(1, 32'h7F80_0000, 32'h7F80_0000, 1, 0);
        chk("inf_sub_byp", 32'(out_bypass), 32'd1);
        chk("inf_sub_res", out_bypass_result, 32'h7FC0_0000);
        cyc(1, 32'h7F80_0000, 32'h7F80_0000, 0, 1);
        chk("inf_add_res", out_bypass_result, 32'h7F80_0000);
        cyc(1, 32'h3F80_0000, 32'h7F80_0000, 1, 1);
        chk("binf_sub_res", out_bypass_result, 32'hFF80_0000);
        cyc(1, 32'h7F80_0001, 32'h3F80_0000, 0, 1);
        chk("nan_res", out_bypass_result, 32'h7FC0_0000);
        cyc(0, 0, 0, 0, 1);

        // denormal flush
        cyc(1, 32'h8000_0001, 32'h0040_0000, 0, 0);
        chk("den_a",     out_a, 32'h8000_0000);
        chk("den_b",     out_b, 32'h0000_0000);
        chk("den_count", 32'(flush_count), 32'd2);
        cyc(0, 0, 0, 0, 1);

        // random mix with random handshakes
        for (int i = 0; i < 60; i++)
            cyc($urandom_range(0, 1), rnd_fp(), rnd_fp(), $urandom_range(0, 1), $urandom_range(0, 1));
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(0, 0, 0, 0, 1);

        // saturate the flush counter
        for (int i = 0; i < 130; i++)
            cyc(1, 32'h0000_0001, 32'h8000_0003, 0, 1);
        chk("flush_sat", 32'(flush_count), 32'd255);
        cyc(1, 32'h0000_0005, 32'h0000_0007, 1, 1);
        chk("flush_hold", 32'(flush_count), 32'd255);
        cyc(0, 0, 0, 0, 1);

        // async reset mid-stream at level 3
        for (int i = 0; i < 3; i++)
            cyc(1, 32'h4500_0000 + i, 32'h4600_0000 + i, 0, 0);
        chk("pre_rst_level", 32'(level), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_level", 32'(level),     32'd0);
        chk("mid_rst_a",     out_a,          32'd0);
        sb.delete();
        exp_flush = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        cyc(1, 32'h4700_0000, 32'h4800_0000, 0, 0);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_a",     out_a,      32'h4700_0000);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ieee_adder_issue.md
# ieee_adder_issue

Operand issue stage directly upstream of the combinational IEEE-754 single-precision adder datapath. It accepts operand pairs and an add/sub bit over a valid/ready handshake and buffers them in a first-word-fall-through FIFO. At enqueue it classifies special operands: NaN and infinity results are resolved here and flagged as bypass, and denormal inputs are flushed to signed zero. The head entry drives the adder inputs, or the result mux when bypass is set.

## Interface

**Parameters**
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `CNT_W`, 8: width of the saturating flush counter.

**Ports**
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an operand pair is offered.
- `in_ready` out 1: stage can accept; equals `!full`.
- `in_a` in 32: operand A, IEEE-754 single.
- `in_b` in 32: operand B, IEEE-754 single.
- `in_sub` in 1: 1 means A−B, 0 means A+B.
- `out_valid` out 1: head entry present; equals `!empty`.
- `out_ready` in 1: downstream consumes head.
- `out_a` out 32: head operand A, after denormal flush.
- `out_b` out 32: head operand B, after denormal flush.
- `out_sub` out 1: head add/sub bit.
- `out_bypass` out 1: head result is resolved here; adder output must be ignored.
- `out_bypass_result` out 32: resolved special result; 0 when `out_bypass`=0.
- `flush_count` out CNT_W: number of denormal operands flushed; saturates at all-ones.
- `level` out log2(DEPTH)+1: current occupancy.

## Operation

**Handshake**
- Push when `in_valid && in_ready`.
- Pop when `out_valid && out_ready`.
- `in_ready` depends only on state, never on `out_ready`. Push while full is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle, non-full and non-empty: occupancy unchanged, both pointers advance.
- Pop while empty: ignored.
- Payload inputs are don't-care when `in_valid`=0.

**Storage**
- Circular buffer with `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
- `level` counter: 0..DEPTH. `full` = (level==DEPTH); `empty` = (level==0).
- Each entry holds {a', b', sub, bypass, bypass_result}, all computed at enqueue time.
- Outputs are read combinationally from the entry at `rd_ptr` (first-word fall-through).
- When empty, `out_a`, `out_b`, `out_sub`, `out_bypass` and `out_bypass_result` are driven to 0.

**Classification (per operand x, at enqueue)**
- Fields: e = x[30:23], m = x[22:0].
- NaN: e=255 and m≠0.
- Inf: e=255 and m=0.
- Denormal: e=0 and m≠0. Flushed to x[31] followed by 31 zero bits.
- Effective sign of B is b[31]^sub.

**Bypass rules, checked in order**
1. Either operand NaN → bypass, result 0x7FC00000.
2. A Inf and B Inf with differing effective signs → bypass, result 0x7FC00000.
3. A Inf → bypass, result {a[31], 8'hFF, 23'h0}.
4. B Inf → bypass, result {b[31]^sub, 8'hFF, 23'h0}.
5. Otherwise bypass=0 and result=0.

Operands are stored after flush regardless of bypass.

**Flush counter**
- On an accepted push, `flush_count` increments by the number of denormal operands in the pair (0, 1 or 2).
- Saturates at 2^CNT_W−1 and never wraps.
- Refused pushes do not count.

**Reset**
- Asynchronous assertion clears `wr_ptr`, `rd_ptr`, `level` and `flush_count` to 0.
- Outputs while reset is asserted: `in_ready`=1, `out_valid`=0, all data outputs 0, `level`=0.
- Entry contents need no reset.
- Reset mid-operation discards all buffered entries; no partial push or pop completes in that cycle.

## Timing

- Latency from accepted push to `out_valid`: 1 cycle, when the FIFO was empty.
- Throughput: 1 pair per cycle while neither full nor stalled.
- The entry becomes visible on the edge after the push.
- `in_ready` deasserts on the edge at which `level` reaches DEPTH.
- `in_ready` reasserts on the edge following the first pop from full.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- `flush_count` updates on the same edge as the push.

## Test plan

- Reset, then push A=0x3F800000, B=0x40000000, sub=0 → next cycle: `out_valid`=1, `out_a`=0x3F800000, `out_bypass`=0, `level`=1.
- Push DEPTH=4 pairs with `out_ready`=0 → `in_ready`=0 after the 4th edge, 5th push refused. Then 4 pops → data in original order, `level`=0, `out_valid`=0.
- Simultaneous push and pop at `level`=2 for 10 cycles (pointers wrap) → `level` stays 2, output order preserved.
- A=0x7F800000, B=0x7F800000, sub=1 → `out_bypass`=1, `out_bypass_result`=0x7FC00000. Same operands with sub=0 → result 0x7F800000.
- A=0x80000001, B=0x00400000 → `out_a`=0x80000000, `out_b`=0x00000000, `flush_count` +2. Preload counter near 255 with CNT_W=8 → saturates at 255.
- Assert `rst` with `level`=3 mid-stream → immediately `out_valid`=0 and `in_ready`=1; after release, first push appears alone with `level`=1.
